// File: rtl/if_fetch_pkg.sv
// Shared widths, stall encoding and bus payloads for the instruction-fetch stage.
// IF_ADDR_CHECK_EN widens the IF->ID bus with an address-error flag.
package if_fetch_pkg;

    localparam int unsigned STALL_WD = 6;
    localparam int unsigned BR_WD    = 33;
`ifdef IF_ADDR_CHECK_EN
    localparam int unsigned IF_TO_ID_WD = 34;
`else
    localparam int unsigned IF_TO_ID_WD = 33;
`endif

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
`ifdef IF_ADDR_CHECK_EN
        logic        adel;
`endif
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    typedef enum logic {
        HS_PASS = 1'b0,
        HS_HOLD = 1'b1
    } hold_state_t;

endpackage

// File: rtl/if_inst_hold.sv
// Keeps the fetched instruction stable while decode is stalled so that it
// stays paired with the PC registered in decode.
module if_inst_hold
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall1,
    input  logic [31:0] rdata,
    output logic [31:0] inst_o
);

    hold_state_t state;
    logic [31:0] hold_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HS_PASS;
            hold_inst <= 32'd0;
        end else begin
            case (state)
                HS_PASS: begin
                    if (stall1 == Stop) begin
                        hold_inst <= rdata;
                        state     <= HS_HOLD;
                    end
                end
                HS_HOLD: begin
                    if (stall1 == NoStop) begin
                        state <= HS_PASS;
                    end
                end
                default: state <= HS_PASS;
            endcase
        end
    end

    assign inst_o = (state == HS_HOLD) ? hold_inst : rdata;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, SRAM request and branch redirect,
// with redirects that arrive during a PC stall deferred until it releases.
// IF_ADDR_CHECK_EN adds misaligned-fetch detection (adel).
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [31:0]            inst_o
);

    br_bus_t     br;
    if_to_id_t   bus_s;
    logic [31:0] pc_r;
    logic        ce_r;
    logic        pend_v;
    logic [31:0] pend_addr;
    logic [31:0] next_pc;
    logic [31:0] held_inst;
    logic        unused_stall;

    assign br           = br_bus_t'(br_bus);
    assign unused_stall = ^stall[STALL_WD-1:2];

    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br.br_e) begin
            next_pc = br.br_addr;
        end else if (pend_v) begin
            next_pc = pend_addr;
        end
    end

    // A branch resolved while the PC is frozen is parked; the newest one wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            ce_r      <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 32'd0;
        end else if (stall[0] == NoStop) begin
            pc_r   <= next_pc;
            ce_r   <= 1'b1;
            pend_v <= 1'b0;
        end else if (br.br_e) begin
            pend_v    <= 1'b1;
            pend_addr <= br.br_addr;
        end
    end

    if_inst_hold u_hold (
        .clk    (clk),
        .rst    (rst),
        .stall1 (stall[1]),
        .rdata  (inst_sram_rdata),
        .inst_o (held_inst)
    );

`ifdef IF_ADDR_CHECK_EN
    logic adel;
    logic adel_q;

    assign adel = ce_r & (pc_r[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= adel;
        end
    end

    assign inst_sram_en = ce_r & ~adel;
    assign inst_o       = adel_q ? 32'd0 : held_inst;
    assign bus_s.adel   = adel;
`else
    assign inst_sram_en = ce_r;
    assign inst_o       = held_inst;
`endif

    assign bus_s.ce        = ce_r;
    assign bus_s.pc        = pc_r;
    assign if_to_id_bus    = bus_s;
    assign inst_sram_addr  = pc_r;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: expected fetch addresses go into a
// scoreboard queue as stimulus is applied and are popped after each edge.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [STALL_WD-1:0]    stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [31:0]            inst_sram_rdata;
    logic [31:0]            inst_o;

    logic [31:0] sram_q;
    logic        ovr_en;
    logic [31:0] ovr_val;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_o          (inst_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous SRAM: data for the address presented at an edge appears after it.
    always @(posedge clk) sram_q <= mem_word(inst_sram_addr);
    assign inst_sram_rdata = ovr_en ? ovr_val : sram_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = '0; br_bus = '0; ovr_en = 1'b0; ovr_val = 32'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inst_sram_en !== 1'b0) begin
                errors++; $display("FAIL reset_en cyc%0d: got %b want 0", i, inst_sram_en);
            end
            checks++;
            if (inst_sram_addr !== RESET_PC) begin
                errors++; $display("FAIL reset_addr cyc%0d: got %h want %h", i, inst_sram_addr, RESET_PC);
            end
            step();
        end
        checks++;
        if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'd0) begin
            errors++; $display("FAIL write_tieoff: wen %b wdata %h want 0", inst_sram_wen, inst_sram_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp, prev;
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        exp_q.push_back(32'hBFC0_0008);
        prev = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = exp_q.pop_front();
            checks++;
            if (inst_sram_addr !== exp || inst_sram_en !== 1'b1) begin
                errors++; $display("FAIL seq_addr %0d: got %h en %b want %h en 1", i, inst_sram_addr, inst_sram_en, exp);
            end
            checks++;
            if (if_to_id_bus[32:0] !== {1'b1, exp}) begin
                errors++; $display("FAIL seq_bus %0d: got %h want %h", i, if_to_id_bus[32:0], {1'b1, exp});
            end
            if (i > 0) begin
                checks++;
                if (inst_o !== mem_word(prev)) begin
                    errors++; $display("FAIL fetch_latency %0d: got %h want %h", i, inst_o, mem_word(prev));
                end
            end
            prev = exp;
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp;
        br_bus = {1'b1, 32'hBFC0_0100};
        exp_q.push_back(32'hBFC0_0100);
        exp_q.push_back(32'hBFC0_0104);
        for (int i = 0; i < 2; i++) begin
            step();
            br_bus = '0;
            exp = exp_q.pop_front();
            checks++;
            if (inst_sram_addr !== exp) begin
                errors++; $display("FAIL branch_addr %0d: got %h want %h", i, inst_sram_addr, exp);
            end
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] exp;
        stall[0] = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hBFC0_0104);
        for (int i = 0; i < 3; i++) begin
            br_bus = (i == 1) ? {1'b1, 32'h8000_0040} : '0;
            step();
            exp = exp_q.pop_front();
            checks++;
            if (inst_sram_addr !== exp) begin
                errors++; $display("FAIL stall_freeze %0d: got %h want %h", i, inst_sram_addr, exp);
            end
        end
        br_bus = '0;
        stall[0] = 1'b0;
        exp_q.push_back(32'h8000_0040);
        exp_q.push_back(32'h8000_0044);
        for (int i = 0; i < 2; i++) begin
            step();
            exp = exp_q.pop_front();
            checks++;
            if (inst_sram_addr !== exp) begin
                errors++; $display("FAIL deferred_redirect %0d: got %h want %h", i, inst_sram_addr, exp);
            end
        end
    endtask

    task automatic test_br_over_pending();
        logic [31:0] exp;
        stall[0] = 1'b1;
        br_bus = {1'b1, 32'h8000_1000};
        step();
        br_bus = '0;
        step();
        stall[0] = 1'b0;
        br_bus = {1'b1, 32'h8000_2000};
        exp_q.push_back(32'h8000_2000);
        exp_q.push_back(32'h8000_2004);
        for (int i = 0; i < 2; i++) begin
            step();
            br_bus = '0;
            exp = exp_q.pop_front();
            checks++;
            if (inst_sram_addr !== exp) begin
                errors++; $display("FAIL br_over_pending %0d: got %h want %h", i, inst_sram_addr, exp);
            end
        end
    endtask

    task automatic test_hold();
        ovr_en = 1'b1;
        ovr_val = 32'h3C01_BFC0;
        #1;
        checks++;
        if (inst_o !== 32'h3C01_BFC0) begin
            errors++; $display("FAIL hold_pass: got %h want 3c01bfc0", inst_o);
        end
        stall[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            ovr_val = 32'h0000_0000;
            #1;
            checks++;
            if (inst_o !== 32'h3C01_BFC0) begin
                errors++; $display("FAIL hold_keep %0d: got %h want 3c01bfc0", i, inst_o);
            end
        end
        stall[1] = 1'b0;
        #1;
        checks++;
        if (inst_o !== 32'h3C01_BFC0) begin
            errors++; $display("FAIL hold_release_cycle: got %h want 3c01bfc0", inst_o);
        end
        step();
        checks++;
        if (inst_o !== 32'h0000_0000) begin
            errors++; $display("FAIL hold_back_to_pass: got %h want 0", inst_o);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        ovr_en = 1'b1;
        ovr_val = 32'hAAAA_0001;
        stall[1:0] = 2'b11;
        br_bus = {1'b1, 32'h8000_3000};
        step();
        br_bus = '0;
        ovr_val = 32'h1234_5678;
        #1;
        checks++;
        if (inst_o !== 32'hAAAA_0001) begin
            errors++; $display("FAIL pre_reset_hold: got %h want aaaa0001", inst_o);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (inst_sram_en !== 1'b0 || inst_sram_addr !== RESET_PC) begin
            errors++; $display("FAIL async_reset_pc: en %b addr %h want 0 %h", inst_sram_en, inst_sram_addr, RESET_PC);
        end
        checks++;
        if (inst_o !== 32'h1234_5678) begin
            errors++; $display("FAIL async_reset_inst: got %h want 12345678", inst_o);
        end
        step();
        rst = 1'b0;
        stall = '0;
        ovr_en = 1'b0;
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        for (int i = 0; i < 2; i++) begin
            step();
            exp = exp_q.pop_front();
            checks++;
            if (inst_sram_addr !== exp || inst_sram_en !== 1'b1) begin
                errors++; $display("FAIL reset_restart %0d: got %h en %b want %h", i, inst_sram_addr, inst_sram_en, exp);
            end
        end
    endtask

`ifdef IF_ADDR_CHECK_EN
    task automatic test_addr_check();
        br_bus = {1'b1, 32'hBFC0_0102};
        step();
        br_bus = '0;
        checks++;
        if (if_to_id_bus[33] !== 1'b1 || inst_sram_en !== 1'b0 || inst_sram_addr !== 32'hBFC0_0102) begin
            errors++; $display("FAIL adel_flag: adel %b en %b addr %h want 1 0 bfc00102",
                               if_to_id_bus[33], inst_sram_en, inst_sram_addr);
        end
        step();
        checks++;
        if (inst_o !== 32'd0) begin
            errors++; $display("FAIL adel_inst: got %h want 0", inst_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_redirect();
        test_br_over_pending();
        test_hold();
        test_async_reset();
`ifdef IF_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
